// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//   Memory-mapped countdown timer serving the data-memory stage's timer
//   window. Three word registers live at BASE_ADDR:
//     +0 CTRL   [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x = 00),
//               [3] IM (interrupt mask), [7:4] PSC when TC_PRESCALE_EN
//     +4 PRESET reload value
//     +8 COUNT  current count, read-only
//     +C unmapped (reads 0, writes ignored)
//
//   Optional feature macro: TC_PRESCALE_EN adds a 4-bit prescaler
//   (CTRL[7:4]) so COUNT decrements once every PSC+1 cycles.
//
// Ports
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   Addr   in   [31:0] byte address from the M stage (Addr[1:0] ignored)
//   WE     in   write strobe (PrWE)
//   Din    in   [31:0] write data
//   Dout   out  [31:0] read data, combinational, 0 when not selected
//   IRQ    out  interrupt request = CTRL.IM & irq_flag, registered
// ---------------------------------------------------------------------------
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [27:0] BASE_TAG = BASE_ADDR[31:4];

  // Architectural state
  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  logic        irq_q;
`ifdef TC_PRESCALE_EN
  logic [3:0]  psc_q;
  logic [3:0]  psc_cnt_q;
  logic [3:0]  psc_d;
`endif

  // Next values for the CPU-visible control bits
  logic        en_d;
  logic [1:0]  mode_d;
  logic        im_d;
  logic [31:0] preset_d;
  logic        irq_flag_d;

  // Bus decode
  logic        sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_any;

  // Timer events
  logic        auto_reload;
  logic        tick;
  logic        cnt_expire;
  logic        int_oneshot;
  logic        int_auto;

  logic [31:0] ctrl_rd;

  // Byte-lane bits carry no meaning for word registers.
  logic        unused_addr;
  assign unused_addr = ^Addr[1:0];

  // -------------------------------------------------------------------------
  // Address decode: the +C slot is deliberately left out of the window so it
  // neither reads back nor accepts writes.
  // -------------------------------------------------------------------------
  always_comb begin
    sel       = (Addr[31:4] == BASE_TAG) && (Addr[3:2] != 2'b11);
    wr_ctrl   = sel && WE && (Addr[3:2] == 2'b00);
    wr_preset = sel && WE && (Addr[3:2] == 2'b01);
    wr_any    = wr_ctrl | wr_preset;
  end

  // MODE 1x is treated as one-shot, so only the exact 01 code reloads.
  assign auto_reload = (mode_q == 2'b01);

`ifdef TC_PRESCALE_EN
  assign tick = (psc_cnt_q == psc_q);
`else
  assign tick = 1'b1;
`endif

  // A count of 0 or 1 on a tick both end the countdown; 0 covers a PRESET of
  // zero, which expires on the first tick after LOAD.
  assign cnt_expire  = (state_q == S_CNT) && en_q && tick && (count_q <= 32'd1);
  assign int_oneshot = (state_q == S_INT) && !auto_reload;
  assign int_auto    = (state_q == S_INT) &&  auto_reload;

  // -------------------------------------------------------------------------
  // Control / flag next-state. Ordering encodes the collision rules:
  //  - one-shot EN clear is applied first so a same-cycle CPU CTRL write wins;
  //  - the irq_flag set is applied last so it beats any same-cycle clear.
  // -------------------------------------------------------------------------
  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    irq_flag_d = irq_flag_q;
`ifdef TC_PRESCALE_EN
    psc_d      = psc_q;
`endif

    if (int_oneshot) en_d = 1'b0;

    if (wr_ctrl) begin
      en_d   = Din[0];
      mode_d = Din[2:1];
      im_d   = Din[3];
`ifdef TC_PRESCALE_EN
      psc_d  = Din[7:4];
`endif
    end

    if (wr_preset) preset_d = Din;

    if (wr_any || int_auto) irq_flag_d = 1'b0;
    if (cnt_expire)         irq_flag_d = 1'b1;
  end

  // -------------------------------------------------------------------------
  // FSM and register file. IRQ is registered from the next-state values so it
  // tracks IM & irq_flag in the same cycle, with no added latency.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef TC_PRESCALE_EN
      psc_q      <= '0;
      psc_cnt_q  <= '0;
`endif
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= im_d & irq_flag_d;
`ifdef TC_PRESCALE_EN
      psc_q      <= psc_d;
`endif

      case (state_q)
        S_IDLE: begin
`ifdef TC_PRESCALE_EN
          psc_cnt_q <= '0;
`endif
          // Look at the post-write EN so enabling costs one cycle to LOAD.
          if (en_d) state_q <= S_LOAD;
        end

        S_LOAD: begin
          // The value latched before this edge is used; a PRESET write in
          // this same cycle lands at the next LOAD.
          count_q <= preset_q;
`ifdef TC_PRESCALE_EN
          psc_cnt_q <= '0;
`endif
          state_q <= S_CNT;
        end

        S_CNT: begin
          if (!en_q) begin
            state_q <= S_IDLE;
          end else if (tick) begin
`ifdef TC_PRESCALE_EN
            psc_cnt_q <= '0;
`endif
            if (count_q > 32'd1) begin
              count_q <= count_q - 32'd1;
            end else begin
              count_q <= '0;
              state_q <= S_INT;
            end
          end else begin
`ifdef TC_PRESCALE_EN
            psc_cnt_q <= psc_cnt_q + 4'd1;
`endif
          end
        end

        S_INT: begin
          // Auto-reload re-enters LOAD through IDLE because EN stays set.
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl_rd      = '0;
    ctrl_rd[0]   = en_q;
    ctrl_rd[2:1] = mode_q;
    ctrl_rd[3]   = im_q;
`ifdef TC_PRESCALE_EN
    ctrl_rd[7:4] = psc_q;
`endif

    Dout = '0;
    if (sel) begin
      case (Addr[3:2])
        2'b00:   Dout = ctrl_rd;
        2'b01:   Dout = preset_q;
        2'b10:   Dout = count_q;
        default: Dout = '0;
      endcase
    end
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//   Cycle-level scoreboard bench. Each cycle the driver applies the inputs
//   held over the previous cycle to a reference model, drives new inputs and
//   queues the Dout/IRQ the model says the DUT must show in this cycle. A
//   separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  typedef struct {
    logic [31:0] dout;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: timer phase plus the visible registers.
  // phase: 0 waiting for EN, 1 loading, 2 counting down, 3 expired
  int          phase;
  bit          m_en, m_im, m_irq;
  logic [1:0]  m_mode;
  logic [3:0]  m_psc, m_pc;
  logic [31:0] m_pre, m_cnt;

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit sel, wc, wp, tick, fire, en_off, irq_off;
    if (reset) begin
      phase = 0; m_en = 0; m_im = 0; m_irq = 0; m_mode = 0;
      m_psc = 0; m_pc = 0; m_pre = 0; m_cnt = 0;
      return;
    end
    sel = (Addr[31:4] == BASE[31:4]) && (Addr[3:2] != 2'b11);
    wc  = sel && WE && (Addr[3:2] == 2'b00);
    wp  = sel && WE && (Addr[3:2] == 2'b01);
    fire = 0; en_off = 0; irq_off = 0;
`ifdef TC_PRESCALE_EN
    tick = (m_pc == m_psc);
`else
    tick = 1;
`endif
    case (phase)
      0: begin
        m_pc = 0;
        if (wc ? Din[0] : m_en) phase = 1;
      end
      1: begin
        m_cnt = m_pre; m_pc = 0; phase = 2;
      end
      2: begin
        if (!m_en) phase = 0;
        else if (tick) begin
          m_pc = 0;
          if (m_cnt > 1) m_cnt = m_cnt - 1;
          else begin m_cnt = 0; fire = 1; phase = 3; end
        end else m_pc = m_pc + 1;
      end
      default: begin
        if (m_mode == 2'b01) irq_off = 1; else en_off = 1;
        phase = 0;
      end
    endcase
    if (en_off) m_en = 0;
    if (wc) begin
      m_en = Din[0]; m_mode = Din[2:1]; m_im = Din[3];
`ifdef TC_PRESCALE_EN
      m_psc = Din[7:4];
`endif
    end
    if (wp) m_pre = Din;
    if (wc || wp || irq_off) m_irq = 0;
    if (fire) m_irq = 1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] c;
    if (a[31:4] != BASE[31:4]) return 32'h0;
    c = {28'h0, m_im, m_mode, m_en};
`ifdef TC_PRESCALE_EN
    c[7:4] = m_psc;
`endif
    case (a[3:2])
      2'b00:   return c;
      2'b01:   return m_pre;
      2'b10:   return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk); #1;
    model_step();
    reset = r; WE = we; Addr = a; Din = d;
    cyc++;
    e.dout = model_read(a);
    e.irq  = m_im & m_irq;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(0, 1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) drive(0, 0, a, 32'hDEAD_BEEF);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (Dout !== e.dout) begin
          errors++;
          $display("FAIL dout cyc=%0d got=%h exp=%h", e.cyc, Dout, e.dout);
        end
        checks++;
        if (IRQ !== e.irq) begin
          errors++;
          $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, IRQ, e.irq);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int          r;
    logic [31:0] a, d;
    reset = 1; WE = 0; Addr = 32'h0; Din = 32'h0;
    phase = 0; m_en = 0; m_im = 0; m_irq = 0; m_mode = 0;
    m_psc = 0; m_pc = 0; m_pre = 0; m_cnt = 0;

    // Reset state
    drive(1, 0, BASE + 32'h8, 0);
    drive(1, 0, BASE, 0);
    rd(BASE, 1);
    rd(BASE + 32'h4, 1);

    // One-shot with IRQ held, then PRESET write clears it
    wr(BASE + 32'h4, 5);
    wr(BASE, 32'h9);
    rd(BASE + 32'h8, 9);
    rd(BASE, 2);
    wr(BASE + 32'h4, 3);
    rd(BASE + 32'h8, 3);

    // Auto-reload pulses
    wr(BASE + 32'h4, 2);
    wr(BASE, 32'hB);
    rd(BASE + 32'h8, 12);
    // COUNT write ignored while counting; unmapped reads
    wr(BASE + 32'h8, 32'h1234);
    rd(BASE + 32'h8, 2);
    rd(BASE + 32'hC, 1);
    rd(32'h0000_7F20, 1);
    rd(32'h0000_7F10, 1);

    // Reset mid-count
    drive(1, 0, BASE, 0);
    wr(BASE + 32'h4, 5);
    wr(BASE, 32'h1);
    rd(BASE + 32'h8, 3);
    drive(1, 0, BASE + 32'h8, 0);
    rd(BASE + 32'h8, 2);

    // Collisions: PRESET write as irq_flag sets, CTRL write during INT
    wr(BASE + 32'h4, 1);
    wr(BASE, 32'h9);
    rd(BASE + 32'h8, 1);
    wr(BASE + 32'h4, 4);
    wr(BASE, 32'h9);
    rd(BASE + 32'h8, 8);
    rd(BASE, 1);

`ifdef TC_PRESCALE_EN
    drive(1, 0, BASE, 0);
    wr(BASE + 32'h4, 2);
    wr(BASE, 32'h29);
    rd(BASE + 32'h8, 10);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = BASE + 32'($urandom_range(0, 3)) * 32'd4;
      if (r < 1) begin
        drive(1, 0, a, 0);
      end else if (r < 25) begin
        if (r < 3) a = ($urandom_range(0, 1) == 0) ? 32'h0000_7F20 : 32'h0000_7F10;
        d = (a[3:2] == 2'b01) ? 32'($urandom_range(0, 8)) : $urandom;
        wr(a, d);
      end else begin
        drive(0, 0, a, $urandom);
      end
    end

    @(posedge clk); #2;
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
